// File: rtl/sdc_pkg.sv
// Shared types and constants for the SPI-mode SD card
// power-up/initialisation sequencer.
package sdc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POWERUP,
        ST_CMD0,
        ST_CMD8,
        ST_CMD55,
        ST_ACMD41,
        ST_CMD58,
        ST_TAIL,
        ST_DONE,
        ST_ERR
    } state_e;

    // Sub-step inside every command state
    typedef enum logic [1:0] {
        PH_FRAME,
        PH_POLL,
        PH_TRAIL,
        PH_GAP
    } phase_e;

    typedef enum logic [2:0] {
        CMD_0,
        CMD_8,
        CMD_55,
        CMD_A41,
        CMD_58
    } cmd_e;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_CMD0   = 3'd1;
    localparam logic [2:0] ERR_CMD8   = 3'd2;
    localparam logic [2:0] ERR_ACMD41 = 3'd3;
    localparam logic [2:0] ERR_CMD58  = 3'd4;

    localparam logic [7:0] R1_IDLE      = 8'h01;
    localparam logic [7:0] R1_READY     = 8'h00;
    localparam logic [7:0] CMD8_PATTERN = 8'hAA;
    localparam logic [7:0] FILL         = 8'hFF;

    localparam logic [2:0] FRAME_LAST = 3'd5;
    localparam logic [2:0] TRAIL_LAST = 3'd3;

    function automatic cmd_e state_cmd(input state_e s);
        case (s)
            ST_CMD8:   state_cmd = CMD_8;
            ST_CMD55:  state_cmd = CMD_55;
            ST_ACMD41: state_cmd = CMD_A41;
            ST_CMD58:  state_cmd = CMD_58;
            default:   state_cmd = CMD_0;
        endcase
    endfunction

endpackage

// File: rtl/sdc_cmd_rom.sv
// Command frame ROM: six bytes per command, index 0 goes out first.
// Indices past the frame read back as fill bytes.
module sdc_cmd_rom
    import sdc_pkg::*;
(
    input  cmd_e       cmd_i,
    input  logic [2:0] idx_i,
    output logic [7:0] byte_o
);

    logic [47:0] frame;

    always_comb begin
        frame = {6{FILL}};
        case (cmd_i)
            CMD_0:   frame = 48'h4000_0000_0095;
            CMD_8:   frame = 48'h4800_0001_AA87;
            CMD_55:  frame = 48'h7700_0000_0065;
            CMD_A41: frame = 48'h6940_0000_0077;
            CMD_58:  frame = 48'h7A00_0000_00FD;
            default: frame = {6{FILL}};
        endcase
    end

    always_comb begin
        byte_o = FILL;
        case (idx_i)
            3'd0:    byte_o = frame[47:40];
            3'd1:    byte_o = frame[39:32];
            3'd2:    byte_o = frame[31:24];
            3'd3:    byte_o = frame[23:16];
            3'd4:    byte_o = frame[15:8];
            3'd5:    byte_o = frame[7:0];
            default: byte_o = FILL;
        endcase
    end

endmodule

// File: rtl/sdc_init_ctrl.sv
// SPI-mode SD card initialisation sequencer: CMD0, CMD8, CMD55/ACMD41
// polling and CMD58, then hands the bus to the writer.
module sdc_init_ctrl
    import sdc_pkg::*;
#(
    parameter int unsigned DUMMY_BYTES = 10,
    parameter int unsigned NCR_MAX     = 8,
    parameter int unsigned CMD0_RETRY  = 4,
    parameter int unsigned ACMD41_MAX  = 1000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_init_i,
    input  logic       xfer_done_i,
    input  logic [7:0] xfer_rx_i,
    output logic       xfer_start_o,
    output logic [7:0] xfer_tx_o,
    output logic       cs_n_o,
    output logic       spi_slow_o,
    output logic       busy_o,
    output logic       init_done_o,
    output logic       init_err_o,
    output logic [2:0] err_code_o,
    output logic       sdhc_o
);

    localparam int unsigned PMAX =
        (DUMMY_BYTES > NCR_MAX) ? DUMMY_BYTES : NCR_MAX;
    localparam int PW = $clog2(PMAX + 1);
    localparam int IW = $clog2(ACMD41_MAX + 1);
    localparam int RW = $clog2(CMD0_RETRY + 1);

    state_e         state_q, state_d;
    state_e         tgt_q, tgt_d;
    phase_e         ph_q, ph_d;
    logic [2:0]     idx_q, idx_d;
    logic [PW-1:0]  poll_q, poll_d;
    logic [IW-1:0]  iter_q, iter_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic           pend_q, pend_d;
    logic [2:0]     err_q, err_d;
    logic           sdhc_q, sdhc_d;

    logic           is_cmd;
    logic           xfer_st;
    logic [7:0]     rom_byte;
    logic [7:0]     r1;
    logic [IW-1:0]  iter_inc;
    logic           iter_last;
    cmd_e           cmd_id;

    assign cmd_id  = state_cmd(state_q);
    assign is_cmd  = state_q inside {ST_CMD0, ST_CMD8, ST_CMD55,
                                     ST_ACMD41, ST_CMD58};
    assign xfer_st = is_cmd || (state_q inside {ST_POWERUP, ST_TAIL});

    sdc_cmd_rom u_rom (
        .cmd_i  (cmd_id),
        .idx_i  (idx_q),
        .byte_o (rom_byte)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            tgt_q   <= ST_IDLE;
            ph_q    <= PH_FRAME;
            idx_q   <= '0;
            poll_q  <= '0;
            iter_q  <= '0;
            retry_q <= '0;
            pend_q  <= 1'b0;
            err_q   <= ERR_NONE;
            sdhc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            ph_q    <= ph_d;
            idx_q   <= idx_d;
            poll_q  <= poll_d;
            iter_q  <= iter_d;
            retry_q <= retry_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            sdhc_q  <= sdhc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        ph_d         = ph_q;
        idx_d        = idx_q;
        poll_d       = poll_q;
        iter_d       = iter_q;
        retry_d      = retry_q;
        pend_d       = pend_q;
        err_d        = err_q;
        sdhc_d       = sdhc_q;
        xfer_start_o = 1'b0;
        r1           = FILL;
        iter_inc     = (iter_q == IW'(ACMD41_MAX)) ? iter_q : iter_q + 1'b1;
        iter_last    = iter_q >= IW'(ACMD41_MAX - 1);

        if (xfer_st && !pend_q) begin
            xfer_start_o = 1'b1;
            pend_d       = 1'b1;
        end

        if (xfer_done_i && pend_q) begin
            pend_d = 1'b0;
            case (state_q)
                ST_POWERUP: begin
                    if (poll_q == PW'(DUMMY_BYTES - 1)) begin
                        state_d = ST_CMD0;
                        ph_d    = PH_FRAME;
                        idx_d   = '0;
                        poll_d  = '0;
                    end else begin
                        poll_d = poll_q + 1'b1;
                    end
                end
                ST_TAIL: state_d = ST_DONE;
                default: begin
                    case (ph_q)
                        PH_FRAME: begin
                            if (idx_q == FRAME_LAST) begin
                                ph_d   = PH_POLL;
                                idx_d  = '0;
                                poll_d = '0;
                            end else begin
                                idx_d = idx_q + 3'd1;
                            end
                        end
                        PH_POLL: begin
                            if (!xfer_rx_i[7] ||
                                poll_q == PW'(NCR_MAX - 1)) begin
                                // a poll timeout reads as R1 = 0xFF
                                r1 = xfer_rx_i[7] ? FILL : xfer_rx_i;
                                case (state_q)
                                    ST_CMD0: begin
                                        if (r1 == R1_IDLE) begin
                                            ph_d  = PH_GAP;
                                            tgt_d = ST_CMD8;
                                        end else if (retry_q ==
                                                     RW'(CMD0_RETRY - 1)) begin
                                            state_d = ST_ERR;
                                            err_d   = ERR_CMD0;
                                        end else begin
                                            retry_d = retry_q + 1'b1;
                                            ph_d    = PH_GAP;
                                            tgt_d   = ST_CMD0;
                                        end
                                    end
                                    ST_CMD8: begin
                                        if (r1 == R1_IDLE) begin
                                            ph_d  = PH_TRAIL;
                                            idx_d = '0;
                                        end else begin
                                            state_d = ST_ERR;
                                            err_d   = ERR_CMD8;
                                        end
                                    end
                                    ST_CMD55: begin
                                        if (!r1[7]) begin
                                            ph_d  = PH_GAP;
                                            tgt_d = ST_ACMD41;
                                        end else begin
                                            iter_d = iter_inc;
                                            if (iter_last) begin
                                                state_d = ST_ERR;
                                                err_d   = ERR_ACMD41;
                                            end else begin
                                                ph_d  = PH_GAP;
                                                tgt_d = ST_CMD55;
                                            end
                                        end
                                    end
                                    ST_ACMD41: begin
                                        if (r1 == R1_READY) begin
                                            ph_d  = PH_GAP;
                                            tgt_d = ST_CMD58;
                                        end else if (r1 == R1_IDLE &&
                                                     !iter_last) begin
                                            iter_d = iter_inc;
                                            ph_d   = PH_GAP;
                                            tgt_d  = ST_CMD55;
                                        end else begin
                                            iter_d  = iter_inc;
                                            state_d = ST_ERR;
                                            err_d   = ERR_ACMD41;
                                        end
                                    end
                                    ST_CMD58: begin
                                        if (r1 == R1_READY) begin
                                            ph_d  = PH_TRAIL;
                                            idx_d = '0;
                                        end else begin
                                            state_d = ST_ERR;
                                            err_d   = ERR_CMD58;
                                        end
                                    end
                                    default: ;
                                endcase
                            end else begin
                                poll_d = poll_q + 1'b1;
                            end
                        end
                        PH_TRAIL: begin
                            idx_d = idx_q + 3'd1;
                            if (state_q == ST_CMD58 && idx_q == 3'd0)
                                sdhc_d = xfer_rx_i[6];
                            if (idx_q == TRAIL_LAST) begin
                                idx_d = '0;
                                if (state_q == ST_CMD58) begin
                                    state_d = ST_TAIL;
                                end else if (xfer_rx_i == CMD8_PATTERN) begin
                                    ph_d  = PH_GAP;
                                    tgt_d = ST_CMD55;
                                end else begin
                                    state_d = ST_ERR;
                                    err_d   = ERR_CMD8;
                                end
                            end
                        end
                        PH_GAP: begin
                            state_d = tgt_q;
                            ph_d    = PH_FRAME;
                            idx_d   = '0;
                        end
                        default: ;
                    endcase
                end
            endcase
        end

        if (start_init_i && !xfer_st) begin
            state_d = ST_POWERUP;
            ph_d    = PH_FRAME;
            idx_d   = '0;
            poll_d  = '0;
            iter_d  = '0;
            retry_d = '0;
            pend_d  = 1'b0;
            err_d   = ERR_NONE;
            sdhc_d  = 1'b0;
        end
    end

    assign xfer_tx_o   = (is_cmd && ph_q == PH_FRAME) ? rom_byte : FILL;
    assign cs_n_o      = !(is_cmd && ph_q != PH_GAP);
    assign spi_slow_o  = state_q != ST_DONE;
    assign busy_o      = xfer_st;
    assign init_done_o = state_q == ST_DONE;
    assign init_err_o  = state_q == ST_ERR;
    assign err_code_o  = err_q;
    assign sdhc_o      = sdhc_q;

endmodule
